// File: rtl/vsq_scale_sequencer_if.sv
// rtl/vsq_scale_sequencer_if.sv - command, element and result handshakes of the scale sequencer
interface vsq_scale_sequencer_if #(
    parameter int LEN_W = 6
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_is_vsq;
    logic [7:0]       cmd_a_factor;
    logic [7:0]       cmd_b_factor;
    logic [LEN_W-1:0] cmd_len;

    logic             in_valid;
    logic             in_ready;
    logic [13:0]      in_psum;

    logic             out_valid;
    logic             out_ready;
    logic [23:0]      out_sum;
    logic [LEN_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output cmd_valid, cmd_is_vsq, cmd_a_factor, cmd_b_factor, cmd_len,
        output in_valid, in_psum, out_ready,
        input  cmd_ready, in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  cmd_valid, cmd_is_vsq, cmd_a_factor, cmd_b_factor, cmd_len,
        input  in_valid, in_psum, out_ready,
        output cmd_ready, in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/vsq_scale_sequencer.sv
// rtl/vsq_scale_sequencer.sv - accumulates a vector of partial sums, optionally scaled by (A*B) mod 256
module vsq_scale_sequencer #(
    parameter int LEN_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vsq_scale_sequencer_if.slave bus,
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      acc_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       sprod_q;
    logic             is_vsq_q;
    logic             ovf_q;

    logic             cmd_fire;
    logic             in_fire;
    logic             out_fire;
    logic             last_elem;
    logic [LEN_W-1:0] count_inc;
    logic [21:0]      prod_w;
    logic [21:0]      term_w;
    logic [24:0]      sum_w;
    logic [15:0]      ab_w;

    assign cmd_fire  = (state_q == IDLE) && bus.cmd_valid;
    assign in_fire   = (state_q == RUN)  && bus.in_valid;
    assign out_fire  = (state_q == DONE) && bus.out_ready;
    assign count_inc = count_q + LEN_W'(1);
    assign last_elem = (count_inc == len_q);

    // The 14x8 product fits 22 bits exactly, so the mod 2^22 is implicit.
    assign prod_w = 22'(bus.in_psum) * 22'(sprod_q);
    assign term_w = is_vsq_q ? prod_w : 22'(bus.in_psum);
    assign sum_w  = {1'b0, acc_q} + {3'b000, term_w};
    assign ab_w   = 16'(bus.cmd_a_factor) * 16'(bus.cmd_b_factor);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_fire) state_d = (bus.cmd_len != '0) ? RUN : DONE;
            RUN:  if (in_fire && last_elem) state_d = DONE;
            DONE: if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            len_q    <= '0;
            sprod_q  <= '0;
            is_vsq_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                is_vsq_q <= bus.cmd_is_vsq;
                sprod_q  <= ab_w[7:0];
                len_q    <= bus.cmd_len;
                acc_q    <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else if (in_fire) begin
                acc_q   <= sum_w[23:0];
                count_q <= count_inc;
                if (sum_w[24]) ovf_q <= 1'b1;
            end
        end
    end

    // Every output is a state decode or a datapath register; results persist until the next command.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.in_ready  = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = acc_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_vsq_scale_sequencer.sv
// tb/tb_vsq_scale_sequencer.sv - directed and random vectors scored against a queue of expected results
module tb_vsq_scale_sequencer;
    localparam int LEN_W = 6;

    typedef logic [13:0] psq_t[$];
    typedef struct packed {
        logic [23:0]      sum;
        logic [LEN_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;
    int   n_checks;
    int   n_fails;
    exp_t sb[$];
    psq_t ps;

    vsq_scale_sequencer_if #(.LEN_W(LEN_W)) bus_if ();

    vsq_scale_sequencer #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd1);
        check({tag, "_in_ready"},  32'(bus_if.in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(bus_if.out_sum),   32'd0);
        check({tag, "_out_count"}, 32'(bus_if.out_count), 32'd0);
        check({tag, "_out_ovf"},   32'(bus_if.out_ovf),   32'd0);
        check({tag, "_busy"},      32'(busy),             32'd0);
    endtask

    task automatic drive_cmd(input logic vsq, input logic [7:0] a, input logic [7:0] b,
                             input logic [LEN_W-1:0] len);
        bus_if.cmd_valid    = 1'b1;
        bus_if.cmd_is_vsq   = vsq;
        bus_if.cmd_a_factor = a;
        bus_if.cmd_b_factor = b;
        bus_if.cmd_len      = len;
    endtask

    // Caller is just past a falling edge; returns just past a falling edge with the result consumed.
    task automatic send_vector(input string tag, input logic vsq, input logic [7:0] a,
                               input logic [7:0] b, input psq_t v, input int gap,
                               input int bp, input logic cmd_during_ack);
        logic [7:0]  sp;
        logic [21:0] t;
        logic [24:0] acc;
        logic        ovf;
        exp_t        e;
        sp  = 8'((16'(a) * 16'(b)) % 256);
        acc = '0;
        ovf = 1'b0;
        foreach (v[i]) begin
            t   = 22'(v[i]);
            if (vsq) t = t * 22'(sp);
            acc = {1'b0, acc[23:0]} + {3'b000, t};
            if (acc[24]) ovf = 1'b1;
        end
        e.sum = acc[23:0];
        e.cnt = LEN_W'(v.size());
        e.ovf = ovf;
        sb.push_back(e);

        check({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd1);
        drive_cmd(vsq, a, b, LEN_W'(v.size()));
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);

        foreach (v[i]) begin
            repeat (gap) begin
                check({tag, "_gap_in_ready"}, 32'(bus_if.in_ready), 32'd1);
                @(negedge clk);
            end
            check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
            check({tag, "_run_out_valid"}, 32'(bus_if.out_valid), 32'd0);
            bus_if.in_valid = 1'b1;
            bus_if.in_psum  = v[i];
            @(negedge clk);
            bus_if.in_valid = 1'b0;
        end

        check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        e = sb.pop_front();
        repeat (bp) begin
            check({tag, "_hold_sum"},   32'(bus_if.out_sum),   32'(e.sum));
            check({tag, "_hold_count"}, 32'(bus_if.out_count), 32'(e.cnt));
            check({tag, "_hold_valid"}, 32'(bus_if.out_valid), 32'd1);
            bus_if.in_valid = 1'b1;
            bus_if.in_psum  = 14'h3fff;
            @(negedge clk);
            bus_if.in_valid = 1'b0;
        end
        check({tag, "_out_sum"},   32'(bus_if.out_sum),   32'(e.sum));
        check({tag, "_out_count"}, 32'(bus_if.out_count), 32'(e.cnt));
        check({tag, "_out_ovf"},   32'(bus_if.out_ovf),   32'(e.ovf));
        check({tag, "_done_in_ready"},  32'(bus_if.in_ready),  32'd0);
        check({tag, "_done_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd0);
        bus_if.out_ready = 1'b1;
        if (cmd_during_ack) drive_cmd(1'b0, 8'd1, 8'd1, LEN_W'(1));
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        bus_if.cmd_valid = 1'b0;
        check({tag, "_idle_busy"},      32'(busy),             32'd0);
        check({tag, "_idle_out_valid"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, "_idle_keep_sum"},  32'(bus_if.out_sum),   32'(e.sum));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus_if.cmd_valid    = 1'b0;
        bus_if.cmd_is_vsq   = 1'b0;
        bus_if.cmd_a_factor = '0;
        bus_if.cmd_b_factor = '0;
        bus_if.cmd_len      = '0;
        bus_if.in_valid     = 1'b0;
        bus_if.in_psum      = '0;
        bus_if.out_ready    = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_held");
        rst_n = 1'b1;

        ps = '{14'd10, 14'd20};
        send_vector("scaled", 1'b1, 8'd3, 8'd5, ps, 0, 0, 1'b0);
        ps = '{14'd100, 14'd200, 14'd300};
        send_vector("trunc", 1'b1, 8'h20, 8'h10, ps, 0, 0, 1'b0);
        ps = '{14'd1, 14'd2, 14'd3};
        send_vector("pass_bp", 1'b0, 8'd7, 8'd9, ps, 1, 4, 1'b1);
        ps = {};
        send_vector("zero_len", 1'b1, 8'd9, 8'd9, ps, 0, 2, 1'b0);
        ps = '{14'd16383, 14'd16383, 14'd16383, 14'd16383, 14'd16383};
        send_vector("ovf", 1'b1, 8'd255, 8'd1, ps, 0, 0, 1'b0);
        check("ovf_sticky_idle", 32'(bus_if.out_ovf), 32'd1);

        // Abort a vector after one of three elements.
        drive_cmd(1'b1, 8'd4, 8'd4, LEN_W'(3));
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_psum   = 14'd1000;
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        check("abort_partial_count", 32'(bus_if.out_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_midrun");
        @(negedge clk);
        check_reset_outputs("rst_midrun_hold");
        rst_n = 1'b1;
        ps = '{14'd5, 14'd6, 14'd7};
        send_vector("after_rst", 1'b1, 8'd2, 8'd3, ps, 0, 1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            ps = {};
            for (int j = 0; j < int'($urandom_range(0, 12)); j++)
                ps.push_back(14'($urandom_range(0, 16383)));
            send_vector($sformatf("rand%0d", k), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        ps, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/vsq_scale_sequencer.md
VSQ_SCALE_SEQUENCER -- requirements
Module: vsq_scale_sequencer

Interface
REQ-001 The block SHALL have parameter LEN_W, default 6, giving the width of the vector-length field and the element counter.
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_is_vsq  in  1  1 = apply the per-vector scale; 0 = pass-through.
- cmd_a_factor  in  8  per-vector scale factor A.
- cmd_b_factor  in  8  per-vector scale factor B.
- cmd_len  in  LEN_W  number of elements in the vector; 0 is legal.
- in_valid  in  1  partial-sum element offered.
- in_ready  out  1  element accepted when high together with in_valid.
- in_psum  in  14  unsigned partial sum.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when high together with out_valid.
- out_sum  out  24  accumulated vector result.
- out_count  out  LEN_W  number of elements accumulated.
- out_ovf  out  1  the accumulator wrapped during this vector.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-004 In IDLE: cmd_ready=1, in_ready=0, out_valid=0.
REQ-005 On a cmd handshake, the block SHALL register:
- is_vsq;
- sprod = (cmd_a_factor*cmd_b_factor) mod 256;
- len = cmd_len.
REQ-006 On the same cmd handshake, the block SHALL clear the accumulator, the element counter and the overflow flag.
REQ-007 On the cmd handshake, the next state SHALL be RUN if cmd_len != 0, and DONE if cmd_len == 0.
REQ-008 In RUN: in_ready=1, cmd_ready=0, out_valid=0; cmd_valid is ignored.
REQ-009 Each in handshake SHALL compute term = is_vsq ? (in_psum*sprod) mod 2^22 : in_psum, zero-extended to 24 bits.
REQ-010 Each in handshake SHALL set acc <= (acc + term) mod 2^24 and count <= count+1 in that same clock edge, with zero-cycle input-to-accumulator latency.
REQ-011 When the carry out of bit 23 is 1 on any accumulation, the overflow flag SHALL set and stay set until the next cmd handshake.
REQ-012 On the in handshake where count+1 == len, the next state SHALL be DONE, so out_valid rises the cycle after the last element.
REQ-013 No input cycles are lost: the element counter SHALL be LEN_W bits wide and never wrap, because len <= 2^LEN_W-1.
REQ-014 In DONE: out_valid=1, with out_sum=acc, out_count=count and out_ovf=flag held stable while out_ready=0; in_ready=0 and cmd_ready=0.
REQ-015 On an out handshake, the next state SHALL be IDLE; a cmd offered in that same cycle SHALL NOT be accepted and is taken no earlier than the following cycle.
REQ-016 out_sum, out_count and out_ovf SHALL keep their last values outside DONE, until the next cmd handshake clears them.
REQ-017 in_valid with in_ready=0 SHALL have no effect on any state.
REQ-018 All outputs SHALL be registered or decoded from the state register only, with no combinational path from any input to any output.

Reset
REQ-019 While rst_n=0, regardless of clk, the block SHALL hold:
- state=IDLE, acc=0, count=0, ovf=0, sprod=0, is_vsq=0, len=0;
- cmd_ready=1, in_ready=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, busy=0.
REQ-020 A reset asserted mid-RUN or mid-DONE SHALL abort the vector with no result emitted.
REQ-021 After rst_n deasserts, the first cmd SHALL be accepted on the first rising edge.

Verification
REQ-022 Scaled vector: is_vsq=1, a=3, b=5, len=2, psums 10 and 20 -> one out_valid, the cycle after the second element, with out_sum=450, out_count=2, out_ovf=0.
REQ-023 Scale truncation: is_vsq=1, a=0x20, b=0x10 (sprod=0), len=3, psums 100, 200, 300 -> out_sum=0, out_count=3.
REQ-024 Pass-through with back-pressure:
- stimulus: is_vsq=0, a=7, b=9, len=3, psums 1, 2, 3, with in_valid gapped on alternate cycles; out_ready held low 4 cycles;
- response: out_sum=6 and out_count=3, held stable until out_ready rises, then IDLE.
REQ-025 Zero length: cmd_len=0 -> out_valid=1 the cycle after the cmd handshake, with out_sum=0, out_count=0 and in_ready never high.
REQ-026 Overflow: is_vsq=1, a=255, b=1, len=5, psum 16383 each -> out_sum=4111109 (0x3EBB05), out_ovf=1.
REQ-027 Reset mid-RUN: rst_n=0 after 1 of 3 elements -> all outputs at reset values immediately; after release, a new cmd is accepted on the first edge and its result is unaffected by the aborted vector.
